mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Single-port memory arbiter between the instruction-cache and data-cache request channels and one shared RAM port.
- Sits between the caches block (cache-side request/wait signals) and the RAM model.
- Serialises requests and sequences each RAM transaction through a small FSM.
- Default policy is data priority; a bounded anti-starvation counter guarantees instruction fetches progress.

Parameters:
- ADDR_W, 32, address width of iaddr/daddr/ramaddr.
- DATA_W, 32, data width of all load/store buses.
- STARVE_LIMIT, 4, consecutive D grants allowed while iREN is pending before I is forced; 0 = pure data priority; legal range 0..255.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache address.
- iwait  out  1  low for exactly one cycle when I read completes.
- iload  out  DATA_W  I read data, valid while iwait low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  ADDR_W  dcache address.
- dstore  in  DATA_W  dcache write data.
- dwait  out  1  low for exactly one cycle when D access completes.
- dload  out  DATA_W  D read data, valid while dwait low.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.

Behaviour:
- Clock and reset: one clock, CLK; reset nRST is asynchronous, active-low.
- Reset state: FSM=IDLE; dstreak=0; iwait=1, dwait=1; ramREN=0, ramWEN=0; ramaddr=0, ramstore=0; iload=0, dload=0.
- Reset mid-transaction aborts immediately. No completion pulse is emitted.
- FSM states: IDLE, IACC, DACC.
- IDLE, arbitration (registered; one cycle of arbitration latency):
  - If dREN|dWEN and not (iREN and dstreak==STARVE_LIMIT and STARVE_LIMIT!=0): go to DACC.
  - Else if iREN: go to IACC.
  - Else stay in IDLE.
- dstreak update on grant:
  - On a D grant with iREN high: dstreak++ (saturate at 255).
  - On a D grant with iREN low: dstreak=0.
  - On an I grant: dstreak=0.
- IACC:
  - ramREN=1, ramaddr=iaddr (live).
  - When ramstate==ACCESS: iwait=0 and iload=ramload, combinational, that cycle; next state IDLE.
- DACC:
  - If dWEN: ramWEN=1, ramstore=dstore. dWEN wins if dREN and dWEN are both high.
  - Else: ramREN=1.
  - ramaddr=daddr.
  - When ramstate==ACCESS: dwait=0 and dload=ramload; next state IDLE.
- Outside a completion cycle: iwait and dwait are held at 1; iload and dload are driven 0.
- ramstate FREE or BUSY while in IACC/DACC: hold state and strobes.
- ramstate ERROR while in IACC/DACC: drop strobes that cycle; waits stay 1; return to IDLE and re-arbitrate (automatic retry).
- Request withdrawn in IACC/DACC (owner's REN/WEN low): abort to IDLE next cycle; strobes low that cycle; no wait pulse.
- Only one of ramREN/ramWEN is ever high; both are 0 in IDLE.
- A completed requester that keeps its request high is re-arbitrated from IDLE. Back-to-back transactions cost at least 2 cycles each (IDLE + ACC).

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds two outputs:
  - icount, out, 16: number of completed I transactions.
  - dcount, out, 16: number of completed D transactions.
  - Both increment on the respective completion cycle, saturate at 16'hFFFF, and reset to 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset mid-DACC: assert nRST=0 while ramstate=BUSY -> strobes=0 and iwait=dwait=1 immediately; after release, FSM is IDLE.
- I-only read: iREN=1, iaddr=0x40; RAM returns ACCESS on the 3rd cycle with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40; iwait=0 and iload=0xDEADBEEF for exactly one cycle.
- Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x80, dstore=0x1234), STARVE_LIMIT=4 -> D is granted first (ramWEN=1, ramaddr=0x80, ramstore=0x1234); the I grant follows after D completes.
- Starvation: iREN held and dREN re-requested continuously, STARVE_LIMIT=4 -> exactly 4 D completions, then 1 I completion, then D resumes.
- ERROR retry: dREN=1, first ramstate=ERROR then ACCESS -> no dwait pulse on ERROR; D is regranted; dwait=0 on the later ACCESS cycle.
- Withdrawal and stats: iREN dropped during IACC while BUSY -> IDLE next cycle with no iwait pulse. With MEM_ARB_STATS_EN, after 3 I and 2 D completions -> icount=3, dcount=2.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache/RAM bus bundle for mem_arbiter.
// slave: arbiter view; master: caches + RAM model view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// I/D cache to single RAM port arbiter, data priority with starvation cap.
// Optional MEM_ARB_STATS_EN adds icount/dcount completion counters.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   icount,
    output logic [15:0]   dcount
`endif
);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_e;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam logic [7:0] LIMIT     = 8'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic [7:0] dstreak_q, dstreak_d;

    logic d_req, force_i, i_done, d_done, rs_end;

    assign d_req   = bus.dREN | bus.dWEN;
    assign force_i = bus.iREN && (LIMIT != 8'd0)
                     && (dstreak_q == LIMIT);
    assign rs_end  = (bus.ramstate == RS_ACCESS)
                     || (bus.ramstate == RS_ERROR);
    assign i_done  = (state_q == IACC) && bus.iREN
                     && (bus.ramstate == RS_ACCESS);
    assign d_done  = (state_q == DACC) && d_req
                     && (bus.ramstate == RS_ACCESS);

    // State and streak registers; reset aborts any transaction.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
        end
    end

    // Arbitration and transaction sequencing.
    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && !force_i) begin
                    state_d = DACC;
                    if (!bus.iREN)
                        dstreak_d = 8'd0;
                    else if (dstreak_q != 8'hFF)
                        dstreak_d = dstreak_q + 8'd1;
                end else if (bus.iREN) begin
                    state_d   = IACC;
                    dstreak_d = 8'd0;
                end
            end
            IACC: begin
                if (!bus.iREN || rs_end)
                    state_d = IDLE;
            end
            DACC: begin
                if (!d_req || rs_end)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM strobes and cache-side completion signals.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        unique case (state_q)
            IACC: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN
                              && (bus.ramstate != RS_ERROR);
            end
            DACC: begin
                bus.ramaddr = bus.daddr;
                if (bus.dWEN) begin
                    bus.ramWEN   = bus.ramstate != RS_ERROR;
                    bus.ramstore = bus.dstore;
                end else begin
                    bus.ramREN = bus.dREN
                                 && (bus.ramstate != RS_ERROR);
                end
            end
            default: ;
        endcase
        if (i_done) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
        end
        if (d_done) begin
            bus.dwait = 1'b0;
            bus.dload = bus.ramload;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] icount_q, icount_d;
    logic [15:0] dcount_q, dcount_d;

    // Completion counters, saturating.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount_q <= 16'd0;
            dcount_q <= 16'd0;
        end else begin
            icount_q <= icount_d;
            dcount_q <= dcount_d;
        end
    end

    // Counter increment on completion cycles.
    always_comb begin
        icount_d = icount_q;
        dcount_d = dcount_q;
        if (i_done && icount_q != 16'hFFFF)
            icount_d = icount_q + 16'd1;
        if (d_done && dcount_q != 16'hFFFF)
            dcount_d = dcount_q + 16'd1;
    end

    assign icount = icount_q;
    assign dcount = dcount_q;
`endif
endmodule
